// File: rtl/cdc_channel_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake CDC source port among NUM_REQ requesters.
// Optional stall timeout enabled with `define CDC_ARB_TIMEOUT_EN.
module cdc_channel_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int MIN_GAP        = 0,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int ID_WIDTH      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           src_clk,
   input  logic                           src_rst_n,
   input  logic                           arb_en,
   input  logic [NUM_REQ-1:0]             req_mask,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [ID_WIDTH+DATA_WIDTH-1:0] cdc_data,
   output logic                           cdc_valid,
   input  logic                           cdc_ready,
   output logic                           busy,
   output logic [ID_WIDTH-1:0]            last_id,
   output logic                           err_timeout,
   input  logic                           err_clr
);

   localparam logic [7:0] GAP_LOAD = (MIN_GAP > 0) ? 8'(MIN_GAP - 1) : 8'd0;

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t                  state, state_nx;
   logic [ID_WIDTH-1:0]     ptr;
   logic [ID_WIDTH-1:0]     win;
   logic [ID_WIDTH:0]       cand;
   logic                    found;
   logic [NUM_REQ-1:0]      elig;
   logic [DATA_WIDTH-1:0]   win_data;
   logic                    grant;
   logic                    handshake;
   logic                    timeout_hit;
   logic [7:0]              gap_cnt;

`ifdef CDC_ARB_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [STALL_W-1:0] stall_cnt;
`endif

   // Search upward from ptr+1 with wrap; the first eligible index wins.
   always_comb begin
      elig  = req_valid & ~req_mask;
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, ptr} + (ID_WIDTH+1)'(k);
         if (cand >= (ID_WIDTH+1)'(NUM_REQ))
            cand = cand - (ID_WIDTH+1)'(NUM_REQ);
         if (!found && elig[cand[ID_WIDTH-1:0]]) begin
            found = 1'b1;
            win   = cand[ID_WIDTH-1:0];
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++)
         if (win == ID_WIDTH'(i))
            win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   always_ff @(posedge src_clk or negedge src_rst_n) begin
      if (!src_rst_n) state <= IDLE;
      else            state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      req_ready   = '0;
      grant       = 1'b0;
      handshake   = 1'b0;
      timeout_hit = 1'b0;
      unique case (state)
         IDLE: begin
            if (arb_en && found) begin
               grant          = 1'b1;
               req_ready[win] = 1'b1;
               state_nx       = SEND;
            end
         end
         SEND: begin
            if (cdc_ready) begin
               handshake = 1'b1;
               state_nx  = (MIN_GAP > 0) ? GAP : IDLE;
            end
`ifdef CDC_ARB_TIMEOUT_EN
            else if (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_hit = 1'b1;
               state_nx    = IDLE;
            end
`endif
         end
         GAP: begin
            if (gap_cnt == '0) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge src_clk or negedge src_rst_n) begin
      if (!src_rst_n) begin
         cdc_data  <= '0;
         cdc_valid <= 1'b0;
         ptr       <= ID_WIDTH'(NUM_REQ - 1);
         last_id   <= '0;
         gap_cnt   <= '0;
      end else begin
         if (grant) begin
            cdc_data  <= {win, win_data};
            cdc_valid <= 1'b1;
            ptr       <= win;
            last_id   <= win;
         end else if (handshake || timeout_hit) begin
            cdc_valid <= 1'b0;
         end
         if (handshake)
            gap_cnt <= GAP_LOAD;
         else if (state == GAP && gap_cnt != '0)
            gap_cnt <= gap_cnt - 8'd1;
      end
   end

   assign busy = (state != IDLE);

`ifdef CDC_ARB_TIMEOUT_EN
   always_ff @(posedge src_clk or negedge src_rst_n) begin
      if (!src_rst_n) begin
         stall_cnt   <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (grant)
            stall_cnt <= '0;
         else if (state == SEND && !cdc_ready)
            stall_cnt <= stall_cnt + 1'b1;
         // A timeout in the same cycle as err_clr keeps the flag set.
         if (timeout_hit)
            err_timeout <= 1'b1;
         else if (err_clr)
            err_timeout <= 1'b0;
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err_timeout    = 1'b0;
`endif

endmodule
